alu_selfcheck_gen: RTL
======================

// Module: alu_selfcheck_gen
// PURPOSE
//  Synthesizable, self-checking stimulus generator for the N-bit 8-op ALU.
//  Drives a_o/b_o/sel_o, waits LATENCY cycles, compares s/carry/zero/overflow with an internal golden model.
//  Counts mismatches and captures the first failing vector.
//  Sits beside the ALU in the muler test top; replaces the free-running display bench.
// PARAMETERS
//  N         4        operand/result width, 2..16
//  LATENCY   1        cycles from operand drive to DUT result sample, 1..8
//  MODE      0        0 = exhaustive sweep, 1 = LFSR random
//  NUM_RAND  256      vectors issued in MODE=1, 1..65535
//  SEED      32'h1    LFSR seed; 0 is replaced by 1
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous active-high reset
//  start     in   1   one-cycle pulse; begins a run from IDLE or DONE
//  s         in   N   DUT result
//  carry     in   1   DUT carry
//  zero      in   1   DUT zero flag
//  overflow  in   1   DUT signed overflow
//  a_o       out  N   operand A (registered)
//  b_o       out  N   operand B (registered)
//  sel_o     out  3   op select (registered)
//  busy      out  1   run in progress
//  done      out  1   run complete; sticky until next start or rst
//  pass      out  1   done & (err_cnt==0)
//  err_cnt   out  16  mismatching vectors, saturates at 16'hFFFF
//  vec_cnt   out  32  vectors checked this run
//  fail_vld  out  1   first-fail capture valid
//  fail_a/fail_b/fail_sel/fail_s  out  N/N/3/N  first failing vector and DUT result
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, LFSR=SEED (or 1). rst wins over all else; mid-run reset aborts without done.
//  FSM: IDLE -start-> RUN; RUN -last vector checked-> DONE; DONE -start-> RUN. start while RUN is ignored.
//  On start: err_cnt, vec_cnt, fail_* and done cleared; first vector driven at that edge, busy=1.
//  Each vector is held LATENCY cycles. At the LATENCY-th edge after drive, DUT outputs are sampled and compared.
//   The next vector (or DONE) is driven on that same edge. Run length = vectors*LATENCY cycles.
//  Exhaustive order: counter {sel,a,b}, b is LSBs; 0 .. 8*2^(2N)-1. MODE=1: NUM_RAND vectors.
//  LFSR: 32-bit Fibonacci, x^32+x^22+x^2+x+1, steps once per vector.
//   b = lfsr[N-1:0], a = lfsr[2N-1:N], sel = lfsr[2N+2:2N].
//  Golden (N-bit wrap; carry/overflow 0 except add/sub; zero = (s==0) for all ops):
//   000 a+b  carry=bit N of sum; ovf = a,b same sign and s sign differs
//   001 a-b  computed as a+~b+1; carry = no borrow (a>=b unsigned); ovf = signs differ and s sign != a sign
//   010 ~a   011 a&b   100 a|b   101 a^b
//   110 s = {0..,($signed(a)<$signed(b))}   111 s = {0..,(a==b)}
//  Mismatch = any of s/carry/zero/overflow differs. On mismatch err_cnt++ (saturating).
//   If !fail_vld: capture a,b,sel,DUT s and set fail_vld.
//  vec_cnt increments per checked vector. pass is a registered value that updates with done.
//  At DONE: a_o/b_o/sel_o hold the last vector, busy=0, done=1.
// TESTING
//  1 N=4,LAT=1,MODE=0, exact comb ALU, pulse start -> done after 2048 cycles, vec_cnt=2048, err_cnt=0, pass=1.
//  2 As 1, DUT carry stuck 0 -> err_cnt=256 (120 add + 136 sub); fail_sel=000, fail_a=1, fail_b=15, fail_s=0.
//  3 As 1, rst at vec_cnt=100 -> all outputs 0, busy=0, done=0; restart -> full 2048 run, pass=1.
//  4 MODE=1,NUM_RAND=256,SEED=1 -> vec_cnt=256, pass=1; start pulses while busy change nothing.
//  5 LAT=1, DUT with 2-cycle output register -> err_cnt>0; same DUT with LAT=3 -> pass=1.
//  6 N=8, zero flag inverted -> all 524288 vectors fail, err_cnt=16'hFFFF (saturated), vec_cnt=524288.

Source files
------------

// File: rtl/alu_selfcheck_gen.sv
// Purpose : self-checking stimulus generator for an N-bit 8-op ALU (exhaustive sweep or LFSR random).
// Latency : each vector held LATENCY cycles; DUT result sampled on the LATENCY-th edge after drive.
// Backpressure: none; start is ignored while a run is in progress.
// Ports   : clk/rst (sync, active-high), start pulse; s/carry/zero/overflow from the ALU under test;
//           a_o/b_o/sel_o registered operands; busy/done/pass run status; err_cnt (saturating),
//           vec_cnt; fail_vld + fail_a/fail_b/fail_sel/fail_s capture the first mismatching vector.
module alu_selfcheck_gen #(
  parameter int          N        = 4,
  parameter int          LATENCY  = 1,
  parameter int          MODE     = 0,
  parameter int          NUM_RAND = 256,
  parameter logic [31:0] SEED     = 32'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] s,
  input  logic         carry,
  input  logic         zero,
  input  logic         overflow,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic [2:0]   sel_o,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_cnt,
  output logic [31:0]  vec_cnt,
  output logic         fail_vld,
  output logic [N-1:0] fail_a,
  output logic [N-1:0] fail_b,
  output logic [2:0]   fail_sel,
  output logic [N-1:0] fail_s
);

  localparam int          CW       = 3 + 2*N;
  localparam int          LW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [31:0]   lfsr;

  // x^32 + x^22 + x^2 + x + 1, shift-left Fibonacci form
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // {sel,a,b} occupies the low CW bits of the LFSR; for wide N the word is
  // repeated so the sel field still has bits to draw from.
  function automatic logic [CW-1:0] vec_of(input logic [31:0] l);
    return CW'({l, l});
  endfunction

  // Current vector doubles as the exhaustive sweep counter.
  logic [CW-1:0] cur_vec;
  assign cur_vec = {sel_o, a_o, b_o};

  // Golden model on the registered operands
  logic [N:0]   add_w, sub_w;
  logic [N-1:0] g_s;
  logic         g_c, g_z, g_v;

  assign add_w = {1'b0, a_o} + {1'b0, b_o};
  assign sub_w = {1'b0, a_o} + {1'b0, ~b_o} + (N+1)'(1);

  always_comb begin
    g_s = '0;
    g_c = 1'b0;
    g_v = 1'b0;
    case (sel_o)
      3'd0: begin
        g_s = add_w[N-1:0];
        g_c = add_w[N];
        g_v = (a_o[N-1] == b_o[N-1]) && (g_s[N-1] != a_o[N-1]);
      end
      3'd1: begin
        g_s = sub_w[N-1:0];
        g_c = sub_w[N];  // set when there is no borrow
        g_v = (a_o[N-1] != b_o[N-1]) && (g_s[N-1] != a_o[N-1]);
      end
      3'd2:    g_s = ~a_o;
      3'd3:    g_s = a_o & b_o;
      3'd4:    g_s = a_o | b_o;
      3'd5:    g_s = a_o ^ b_o;
      3'd6:    g_s = N'($signed(a_o) < $signed(b_o));
      default: g_s = N'(a_o == b_o);
    endcase
    g_z = (g_s == '0);
  end

  logic        mismatch, check, last;
  logic [15:0] err_nxt;

  assign mismatch = (s != g_s) || (carry != g_c) || (zero != g_z) || (overflow != g_v);
  assign check    = (state == ST_RUN) && (lat_cnt == LW'(LATENCY - 1));
  assign last     = (MODE == 0) ? (&cur_vec) : (vec_cnt == 32'(NUM_RAND - 1));
  assign err_nxt  = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      lfsr     <= SEED_EFF;
      a_o      <= '0;
      b_o      <= '0;
      sel_o    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      vec_cnt  <= '0;
      fail_vld <= 1'b0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_sel <= '0;
      fail_s   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_RUN;
            lat_cnt  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            vec_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_a   <= '0;
            fail_b   <= '0;
            fail_sel <= '0;
            fail_s   <= '0;
            // Random runs restart from the seed so every run is reproducible.
            if (MODE == 0) begin
              {sel_o, a_o, b_o} <= '0;
            end else begin
              {sel_o, a_o, b_o} <= vec_of(SEED_EFF);
              lfsr              <= lfsr_step(SEED_EFF);
            end
          end
        end
        ST_RUN: begin
          if (check) begin
            lat_cnt <= '0;
            vec_cnt <= vec_cnt + 32'd1;
            err_cnt <= err_nxt;
            if (mismatch && !fail_vld) begin
              fail_vld <= 1'b1;
              fail_a   <= a_o;
              fail_b   <= b_o;
              fail_sel <= sel_o;
              fail_s   <= s;
            end
            if (last) begin
              // Operands keep the last vector while idle in DONE.
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == 16'd0);
            end else if (MODE == 0) begin
              {sel_o, a_o, b_o} <= cur_vec + CW'(1);
            end else begin
              {sel_o, a_o, b_o} <= vec_of(lfsr);
              lfsr              <= lfsr_step(lfsr);
            end
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
